// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: owner codes, FSM states,
// default geometry and the word-index range test.
package data_mem_arbiter_pkg;

    localparam int DEPTH_DEF        = 64;
    localparam int LDR_MAX_WAIT_DEF = 4;
    localparam int WAIT_W           = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P    = 2'd1,
        OWN_L    = 2'd2
    } owner_e;

    typedef enum logic {
        ARB_NORM  = 1'b0,
        ARB_FORCE = 1'b1
    } arb_state_e;

    // Word index is the byte address with the low two bits dropped.
    function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
        return (addr >> 2) < 32'(depth);
    endfunction

endpackage

// File: rtl/data_mem_arbiter_wait_counter.sv
// Saturating count of consecutive cycles the loader has been denied;
// hit flags the cycle in which the next denial must turn into a forced grant.
module data_mem_arbiter_wait_counter
    import data_mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = LDR_MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [WAIT_W-1:0] cnt,
    output logic              hit
);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {WAIT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign hit = (cnt_q == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data memory between the pipeline (P, priority) and the
// loader (L, bounded starvation); routes registered read data back to its owner.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int LDR_MAX_WAIT = LDR_MAX_WAIT_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              P_Req,
    input  logic              P_Write,
    input  logic [31:0]       P_Addr,
    input  logic [31:0]       P_WData,
    output logic              P_Gnt,
    output logic              P_Stall,
    output logic              P_RValid,
    output logic [31:0]       P_RData,
    input  logic              L_Req,
    input  logic              L_Write,
    input  logic [31:0]       L_Addr,
    input  logic [31:0]       L_WData,
    output logic              L_Gnt,
    output logic              L_RValid,
    output logic [31:0]       L_RData,
    output logic [31:0]       Mem_Address,
    output logic [31:0]       Mem_WData,
    output logic              Mem_Write,
    output logic              Mem_Read,
    input  logic [31:0]       Mem_RData,
    output logic              Err,
    output logic              dbg_state,
    output logic [WAIT_W-1:0] dbg_wait_cnt
);

    arb_state_e        state_q, state_d;
    owner_e            rd_owner_q, rd_owner_d;
    logic              err_q, err_d;
    logic [31:0]       p_rdata_q, p_rdata_d;
    logic [31:0]       l_rdata_q, l_rdata_d;

    logic              p_gnt, l_gnt, gnt_any;
    logic              wc_clr, wc_inc, wc_hit;
    logic              sel_write, in_range;
    logic [31:0]       sel_addr, sel_wdata, rdata_ret;
    logic [WAIT_W-1:0] wc_cnt;

    data_mem_arbiter_wait_counter #(.MAX_WAIT(LDR_MAX_WAIT)) u_wait_cnt (
        .clk (CLK),
        .rst (RESET),
        .clr (wc_clr),
        .inc (wc_inc),
        .cnt (wc_cnt),
        .hit (wc_hit)
    );

    always_comb begin
        state_d = state_q;
        p_gnt   = 1'b0;
        l_gnt   = 1'b0;
        wc_clr  = 1'b0;
        wc_inc  = 1'b0;
        case (state_q)
            ARB_NORM: begin
                p_gnt = P_Req;
                l_gnt = L_Req & ~P_Req;
                if (P_Req && L_Req) begin
                    wc_inc = 1'b1;
                    if (wc_hit) state_d = ARB_FORCE;
                end else begin
                    wc_clr = 1'b1;
                end
            end
            ARB_FORCE: begin
                l_gnt   = L_Req;
                p_gnt   = P_Req & ~L_Req;
                wc_clr  = 1'b1;
                state_d = ARB_NORM;
            end
            default: state_d = ARB_NORM;
        endcase
        // Nothing may reach memory while the asynchronous reset is asserted.
        if (RESET) begin
            p_gnt = 1'b0;
            l_gnt = 1'b0;
        end
    end

    always_comb begin
        gnt_any   = p_gnt | l_gnt;
        sel_write = p_gnt ? P_Write : L_Write;
        sel_addr  = p_gnt ? P_Addr  : L_Addr;
        sel_wdata = p_gnt ? P_WData : L_WData;
        in_range  = addr_in_range(sel_addr, DEPTH);

        Mem_Address = gnt_any ? sel_addr  : 32'd0;
        Mem_WData   = gnt_any ? sel_wdata : 32'd0;
        Mem_Write   = gnt_any &  sel_write & in_range;
        Mem_Read    = gnt_any & ~sel_write & in_range;

        rd_owner_d = OWN_NONE;
        if (gnt_any && !sel_write) rd_owner_d = p_gnt ? OWN_P : OWN_L;
        err_d = gnt_any & ~in_range;

        // A suppressed out-of-range read returns zero, not whatever memory still holds.
        rdata_ret = err_q ? 32'd0 : Mem_RData;
        P_RValid  = (rd_owner_q == OWN_P);
        L_RValid  = (rd_owner_q == OWN_L);
        P_RData   = P_RValid ? rdata_ret : p_rdata_q;
        L_RData   = L_RValid ? rdata_ret : l_rdata_q;
        p_rdata_d = P_RData;
        l_rdata_d = L_RData;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ARB_NORM;
            rd_owner_q <= OWN_NONE;
            err_q      <= 1'b0;
            p_rdata_q  <= 32'd0;
            l_rdata_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
            err_q      <= err_d;
            p_rdata_q  <= p_rdata_d;
            l_rdata_q  <= l_rdata_d;
        end
    end

    assign P_Gnt        = p_gnt;
    assign L_Gnt        = l_gnt;
    assign P_Stall      = P_Req & ~p_gnt;
    assign Err          = err_q;
    assign dbg_state    = state_q;
    assign dbg_wait_cnt = wc_cnt;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-level reference model with its own memory image.
module tb_data_mem_arbiter;

    localparam int MAXW = 4;
    localparam int DEP  = 64;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        P_Req, P_Write, L_Req, L_Write;
    logic [31:0] P_Addr, P_WData, L_Addr, L_WData;
    logic        P_Gnt, P_Stall, P_RValid, L_Gnt, L_RValid;
    logic [31:0] P_RData, L_RData;
    logic [31:0] Mem_Address, Mem_WData, Mem_RData;
    logic        Mem_Write, Mem_Read, Err;
    logic        dbg_state;
    logic [3:0]  dbg_wait_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:DEP-1];

    data_mem_arbiter #(.DEPTH(DEP), .LDR_MAX_WAIT(MAXW)) dut (
        .CLK(CLK), .RESET(RESET),
        .P_Req(P_Req), .P_Write(P_Write), .P_Addr(P_Addr), .P_WData(P_WData),
        .P_Gnt(P_Gnt), .P_Stall(P_Stall), .P_RValid(P_RValid), .P_RData(P_RData),
        .L_Req(L_Req), .L_Write(L_Write), .L_Addr(L_Addr), .L_WData(L_WData),
        .L_Gnt(L_Gnt), .L_RValid(L_RValid), .L_RData(L_RData),
        .Mem_Address(Mem_Address), .Mem_WData(Mem_WData), .Mem_Write(Mem_Write),
        .Mem_Read(Mem_Read), .Mem_RData(Mem_RData), .Err(Err),
        .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
    );

    // ---------------- clock / reset / memory ----------------
    always #5 CLK = ~CLK;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Mem_RData <= 32'd0;
            for (int i = 0; i < DEP; i++) mem[i] <= 32'd0;
        end else begin
            if (Mem_Write) mem[Mem_Address[7:2]] <= Mem_WData;
            if (Mem_Read)  Mem_RData <= mem[Mem_Address[7:2]];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        P_Req = 0; P_Write = 0; P_Addr = 0; P_WData = 0;
        L_Req = 0; L_Write = 0; L_Addr = 0; L_WData = 0;
    endtask

    task automatic l_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        idle_inputs();
        L_Req = 1; L_Write = 1; L_Addr = a; L_WData = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RESET = 1'b1;
        idle_inputs();
        @(negedge CLK);
        P_Req = 1;
        #2;
        if (P_Gnt !== 1'b0) begin errors++; $display("FAIL reset_p_gnt got %0b want 0", P_Gnt); end checks++;
        if ({L_Gnt, P_RValid, L_RValid, Err} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {L_Gnt, P_RValid, L_RValid, Err}); end checks++;
        if ({P_RData, L_RData} !== 64'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", {P_RData, L_RData}); end checks++;
        if ({Mem_Read, Mem_Write, Mem_Address} !== 34'd0) begin errors++; $display("FAIL reset_mem got %h want 0", {Mem_Read, Mem_Write, Mem_Address}); end checks++;
        if ({dbg_state, dbg_wait_cnt} !== 5'd0) begin errors++; $display("FAIL reset_fsm got %h want 0", {dbg_state, dbg_wait_cnt}); end checks++;
        @(negedge CLK);
        RESET = 1'b0;
        idle_inputs();
    endtask

    task automatic test_read_after_write();
        l_write(32'd8, 32'hDEADBEEF);
        #2;
        if ({L_Gnt, Mem_Write} !== 2'b11) begin errors++; $display("FAIL rw_l_write got %b want 11", {L_Gnt, Mem_Write}); end checks++;
        @(negedge CLK);
        idle_inputs();
        P_Req = 1; P_Addr = 32'd8;
        #2;
        if (P_Gnt !== 1'b1) begin errors++; $display("FAIL rw_p_gnt got %0b want 1", P_Gnt); end checks++;
        if (L_RValid !== 1'b0) begin errors++; $display("FAIL rw_write_no_rvalid got %0b want 0", L_RValid); end checks++;
        @(negedge CLK);
        idle_inputs();
        #2;
        if ({P_RValid, L_RValid} !== 2'b10) begin errors++; $display("FAIL rw_p_rvalid got %b want 10", {P_RValid, L_RValid}); end checks++;
        if (P_RData !== 32'hDEADBEEF) begin errors++; $display("FAIL rw_p_rdata got %h want deadbeef", P_RData); end checks++;
        l_write(32'd4, 32'd7);
        @(negedge CLK);
        idle_inputs();
        P_Req = 1; P_Addr = 32'd4;
        #2;
        if ({P_RValid, L_RValid} !== 2'b00) begin errors++; $display("FAIL rw2_write_no_rvalid got %b want 00", {P_RValid, L_RValid}); end checks++;
        @(negedge CLK);
        idle_inputs();
        #2;
        if (P_RData !== 32'd7) begin errors++; $display("FAIL rw2_p_rdata got %h want 7", P_RData); end checks++;
        @(negedge CLK);
        #2;
        if ({P_RValid, P_RData} !== {1'b0, 32'd7}) begin errors++; $display("FAIL rw2_hold got %h want 7 held", {P_RValid, P_RData}); end checks++;
    endtask

    task automatic test_starvation();
        logic exp_l;
        @(negedge CLK);
        idle_inputs();
        P_Req = 1; P_Write = 1; P_Addr = 32'd12; P_WData = 32'h1111;
        L_Req = 1; L_Write = 1; L_Addr = 32'd16; L_WData = 32'h2222;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge CLK);
            #2;
            exp_l = (k % 5 == 0);
            if ({P_Gnt, L_Gnt, P_Stall} !== {~exp_l, exp_l, exp_l}) begin
                errors++;
                $display("FAIL starve_cycle%0d got pgnt/lgnt/stall=%b want %b", k, {P_Gnt, L_Gnt, P_Stall}, {~exp_l, exp_l, exp_l});
            end
            checks++;
        end
        @(negedge CLK);
        idle_inputs();
    endtask

    task automatic test_out_of_range();
        @(negedge CLK);
        idle_inputs();
        L_Req = 1; L_Addr = 32'h100;
        #2;
        if ({L_Gnt, Mem_Read, Mem_Write} !== 3'b100) begin errors++; $display("FAIL oor_grant got %b want 100", {L_Gnt, Mem_Read, Mem_Write}); end checks++;
        @(negedge CLK);
        idle_inputs();
        #2;
        if ({Err, L_RValid, P_RValid} !== 3'b110) begin errors++; $display("FAIL oor_flags got %b want 110", {Err, L_RValid, P_RValid}); end checks++;
        if (L_RData !== 32'd0) begin errors++; $display("FAIL oor_rdata got %h want 0", L_RData); end checks++;
        @(negedge CLK);
        #2;
        if (Err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse got %0b want 0", Err); end checks++;
    endtask

    task automatic test_alternating();
        logic [31:0] vals [2];
        vals[0] = 32'hA1A1_0000;
        vals[1] = 32'hB2B2_0001;
        l_write(32'd0, vals[0]);
        l_write(32'd4, vals[1]);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            idle_inputs();
            if (i < 4) begin
                if (i % 2 == 0) begin P_Req = 1; P_Addr = 32'd0; end
                else begin L_Req = 1; L_Addr = 32'd4; end
            end
            #2;
            if (i > 0) begin
                if ((i - 1) % 2 == 0) begin
                    if ({P_RValid, L_RValid} !== 2'b10) begin errors++; $display("FAIL alt%0d_rvalid got %b want 10", i, {P_RValid, L_RValid}); end checks++;
                    if (P_RData !== vals[0]) begin errors++; $display("FAIL alt%0d_p_rdata got %h want %h", i, P_RData, vals[0]); end checks++;
                    if (i > 2 && L_RData !== vals[1]) begin errors++; $display("FAIL alt%0d_l_hold got %h want %h", i, L_RData, vals[1]); end
                    if (i > 2) checks++;
                end else begin
                    if ({P_RValid, L_RValid} !== 2'b01) begin errors++; $display("FAIL alt%0d_rvalid got %b want 01", i, {P_RValid, L_RValid}); end checks++;
                    if (L_RData !== vals[1]) begin errors++; $display("FAIL alt%0d_l_rdata got %h want %h", i, L_RData, vals[1]); end checks++;
                    if (P_RData !== vals[0]) begin errors++; $display("FAIL alt%0d_p_hold got %h want %h", i, P_RData, vals[0]); end checks++;
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge CLK);
        idle_inputs();
        P_Req = 1; P_Write = 1; P_Addr = 32'd12;
        L_Req = 1; L_Write = 1; L_Addr = 32'd16;
        @(negedge CLK);
        @(negedge CLK);
        P_Write = 0; P_Addr = 32'd0;
        #2;
        if ({P_Gnt, dbg_wait_cnt} !== {1'b1, 4'd2}) begin errors++; $display("FAIL rstmid_pre got %h want 12", {P_Gnt, dbg_wait_cnt}); end checks++;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        idle_inputs();
        @(negedge CLK);
        #2;
        if ({P_RValid, L_RValid, P_Gnt, L_Gnt, Err, Mem_Read, Mem_Write} !== 7'd0) begin
            errors++; $display("FAIL rstmid_flags got %b want 0", {P_RValid, L_RValid, P_Gnt, L_Gnt, Err, Mem_Read, Mem_Write});
        end
        checks++;
        if ({P_RData, L_RData, Mem_Address} !== 96'd0) begin errors++; $display("FAIL rstmid_data got %h want 0", {P_RData, L_RData, Mem_Address}); end checks++;
        @(negedge CLK);
        RESET = 1'b0;
        #2;
        if ({dbg_state, dbg_wait_cnt, P_RValid} !== 6'd0) begin errors++; $display("FAIL rstmid_release got %h want 0", {dbg_state, dbg_wait_cnt, P_RValid}); end checks++;
    endtask

    task automatic test_random();
        logic [31:0] ref_mem [DEP];
        logic [31:0] p_exp_q [$];
        logic [31:0] l_exp_q [$];
        logic [31:0] exp_p_rd, exp_l_rd, g_addr, g_wdata;
        logic        exp_p_rv, exp_l_rv, exp_err, eg_p, eg_l, g_any, g_wr, oor;
        logic        p_busy, l_busy, force_next;
        int          l_wait;

        RESET = 1'b1;
        idle_inputs();
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < DEP; i++) ref_mem[i] = 32'd0;
        exp_p_rd = 0; exp_l_rd = 0; exp_p_rv = 0; exp_l_rv = 0; exp_err = 0;
        p_busy = 0; l_busy = 0; force_next = 0; l_wait = 0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge CLK);
            if (!p_busy) begin
                P_Req   = ($urandom_range(0, 3) != 0);
                P_Write = 1'($urandom_range(0, 1));
                P_Addr  = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC
                        : ((32'($urandom_range(0, 71)) << 2) | 32'($urandom_range(0, 3)));
                P_WData = $urandom;
            end
            if (!l_busy) begin
                L_Req   = ($urandom_range(0, 2) != 0);
                L_Write = 1'($urandom_range(0, 1));
                L_Addr  = (32'($urandom_range(0, 71)) << 2) | 32'($urandom_range(0, 3));
                L_WData = $urandom;
            end
            #2;
            if (force_next) begin
                eg_l = L_Req;
                eg_p = P_Req & ~L_Req;
            end else begin
                eg_p = P_Req;
                eg_l = L_Req & ~P_Req;
            end
            g_any   = eg_p | eg_l;
            g_wr    = eg_p ? P_Write : L_Write;
            g_addr  = eg_p ? P_Addr  : L_Addr;
            g_wdata = eg_p ? P_WData : L_WData;
            oor     = (g_addr >> 2) >= DEP;
            if (exp_p_rv) exp_p_rd = p_exp_q.pop_front();
            if (exp_l_rv) exp_l_rd = l_exp_q.pop_front();

            if ({P_Gnt, L_Gnt, P_Stall} !== {eg_p, eg_l, P_Req & ~eg_p}) begin
                errors++; $display("FAIL rnd%0d_grant got %b want %b", cyc, {P_Gnt, L_Gnt, P_Stall}, {eg_p, eg_l, P_Req & ~eg_p});
            end
            checks++;
            if ({Mem_Read, Mem_Write} !== {g_any & ~g_wr & ~oor, g_any & g_wr & ~oor}) begin
                errors++; $display("FAIL rnd%0d_mem_ctl got %b want %b", cyc, {Mem_Read, Mem_Write}, {g_any & ~g_wr & ~oor, g_any & g_wr & ~oor});
            end
            checks++;
            if (Mem_Address !== (g_any ? g_addr : 32'd0)) begin
                errors++; $display("FAIL rnd%0d_mem_addr got %h want %h", cyc, Mem_Address, g_any ? g_addr : 32'd0);
            end
            checks++;
            if ({P_RValid, L_RValid, Err} !== {exp_p_rv, exp_l_rv, exp_err}) begin
                errors++; $display("FAIL rnd%0d_ret_flags got %b want %b", cyc, {P_RValid, L_RValid, Err}, {exp_p_rv, exp_l_rv, exp_err});
            end
            checks++;
            if ({P_RData, L_RData} !== {exp_p_rd, exp_l_rd}) begin
                errors++; $display("FAIL rnd%0d_rdata got %h/%h want %h/%h", cyc, P_RData, L_RData, exp_p_rd, exp_l_rd);
            end
            checks++;

            exp_p_rv = eg_p & ~P_Write;
            exp_l_rv = eg_l & ~L_Write;
            exp_err  = g_any & oor;
            if (g_any && !g_wr) begin
                if (eg_p) p_exp_q.push_back(oor ? 32'd0 : ref_mem[g_addr[7:2]]);
                else      l_exp_q.push_back(oor ? 32'd0 : ref_mem[g_addr[7:2]]);
            end
            if (g_any && g_wr && !oor) ref_mem[g_addr[7:2]] = g_wdata;
            if (force_next) begin
                force_next = 0;
                l_wait = 0;
            end else if (P_Req && L_Req) begin
                l_wait++;
                if (l_wait == MAXW) begin
                    force_next = 1;
                    l_wait = 0;
                end
            end else begin
                l_wait = 0;
            end
            p_busy = P_Req & ~eg_p;
            l_busy = L_Req & ~eg_l;
        end
        @(negedge CLK);
        idle_inputs();
    endtask

    initial begin
        RESET = 1'b1;
        idle_inputs();
        test_reset();
        test_read_after_write();
        test_starvation();
        test_out_of_range();
        test_alternating();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
